// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - opcode constants, FSM states and latency helpers for the FP ALU scheduler
package fp_alu_pkg;

  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_DIV = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_F2I = 4'd9;
  localparam logic [3:0] OP_ADD = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;
  localparam logic [3:0] OP_I2F = 4'd12;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } sched_state_t;

  function automatic logic [CNT_W-1:0] op_latency(
    input logic [3:0] op,
    input int         mul_lat,
    input int         div_lat,
    input int         add_lat
  );
    case (op)
      OP_MUL:         op_latency = CNT_W'(mul_lat);
      OP_DIV:         op_latency = CNT_W'(div_lat);
      OP_SUB, OP_ADD: op_latency = CNT_W'(add_lat);
      default:        op_latency = CNT_W'(1);
    endcase
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op != 4'd0) && (op <= OP_I2F);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps upward
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  localparam int SW = IW + 1;

  logic [SW-1:0] sum;
  logic [IW-1:0] k;

  // Walk offsets from farthest to nearest so the nearest requester from ptr is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    sum   = '0;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      k = sum[IW-1:0];
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/fp_alu_sched.sv
// rtl/fp_alu_sched.sv - shares one combinational FP ALU among NREQ requesters with per-opcode hold
module fp_alu_sched
  import fp_alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  input  logic [NREQ*4-1:0]       req_op,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [3:0]              alu_op,
  input  logic [31:0]             alu_result,
  input  logic                    alu_exc,
  input  logic                    alu_ovf,
  input  logic                    alu_unf,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic [$clog2(NREQ)-1:0] resp_tag,
  output logic                    resp_exc,
  output logic                    resp_ovf,
  output logic                    resp_unf,
  input  logic                    flag_clr,
  output logic                    sticky_exc,
  output logic                    sticky_ovf,
  output logic                    sticky_unf,
  output logic                    busy
);

  localparam int TW = $clog2(NREQ);

  sched_state_t     state;
  logic [TW-1:0]    ptr;
  logic [CNT_W-1:0] cnt;
  logic             op_ok;

  logic [NREQ-1:0]  grant;
  logic [TW-1:0]    gidx;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [3:0]       sel_op;

  rr_arbiter #(
    .N  (NREQ),
    .IW (TW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == TW'(i)) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      op_ok      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 4'd0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      resp_exc   <= 1'b0;
      resp_ovf   <= 1'b0;
      resp_unf   <= 1'b0;
      sticky_exc <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      // A clear in the same cycle as a response handshake discards that response's flags.
      if (flag_clr) begin
        sticky_exc <= 1'b0;
        sticky_ovf <= 1'b0;
        sticky_unf <= 1'b0;
      end else if (resp_valid && resp_ready) begin
        sticky_exc <= sticky_exc | resp_exc;
        sticky_ovf <= sticky_ovf | resp_ovf;
        sticky_unf <= sticky_unf | resp_unf;
      end

      case (state)
        ST_IDLE: begin
          if (|grant) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_op   <= sel_op;
            op_ok    <= op_legal(sel_op);
            resp_tag <= gidx;
            ptr      <= (gidx == TW'(NREQ - 1)) ? '0 : gidx + TW'(1);
            cnt      <= op_latency(sel_op, MUL_LAT, DIV_LAT, ADD_LAT);
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Illegal opcodes never trust the ALU: zero data and a forced exception.
            resp_data  <= op_ok ? alu_result : 32'd0;
            resp_exc   <= op_ok ? alu_exc : 1'b1;
            resp_ovf   <= op_ok & alu_ovf;
            resp_unf   <= op_ok & alu_unf;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_alu_sched.sv
// tb/tb_fp_alu_sched.sv - randomized scoreboard bench for fp_alu_sched with a stand-in FP ALU
`timescale 1ns/1ps
module tb_fp_alu_sched;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;
  localparam int ADD_LAT = 2;
  localparam int TW      = 2;

  typedef struct {
    int          tag;
    logic [31:0] data;
    logic        exc;
    logic        ovf;
    logic        unf;
    int          lat;
    int          gcyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_b = '0;
  logic [NREQ*4-1:0]   req_op = '0;
  logic [31:0]         alu_a, alu_b, alu_result;
  logic [3:0]          alu_op;
  logic                alu_exc, alu_ovf, alu_unf;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic [31:0]         resp_data;
  logic [TW-1:0]       resp_tag;
  logic                resp_exc, resp_ovf, resp_unf;
  logic                flag_clr = 1'b0;
  logic                sticky_exc, sticky_ovf, sticky_unf;
  logic                busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  exp_t        sbq[$];
  int          grant_log[$];
  int          m_ptr = 0;
  bit          in_flight = 0;
  logic [31:0] h_a, h_b;
  logic [3:0]  h_op;
  bit [NREQ-1:0] granted_mask = '0;

  fp_alu_sched #(
    .NREQ(NREQ), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ADD_LAT(ADD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_exc(alu_exc), .alu_ovf(alu_ovf), .alu_unf(alu_unf),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_exc(resp_exc), .resp_ovf(resp_ovf), .resp_unf(resp_unf),
    .flag_clr(flag_clr),
    .sticky_exc(sticky_exc), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: crude but deterministic, exact for simple positive-normal adds.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] r;
    logic        e, o, u;
    int          ea, eb, es;
    logic [24:0] ma, mb, s;
    r = '0; e = 1'b0; o = 1'b0; u = 1'b0; ma = '0; mb = '0; s = '0; es = 0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    case (op)
      4'd1: begin
        es = ea + eb - 127; o = (es > 254); u = (es < 1);
        r = {a[31] ^ b[31], 8'(es), a[22:0] ^ b[22:0]};
      end
      4'd2: begin
        es = ea - eb + 127; e = (b[30:0] == 31'd0); o = (es > 254); u = (es < 1);
        r = {a[31] ^ b[31], 8'(es), a[22:0]};
      end
      4'd3:  r = a - b;
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd6:  r = a ^ b;
      4'd7:  r = a << b[4:0];
      4'd8:  r = a >> b[4:0];
      4'd9:  r = {1'b0, a[30:0]};
      4'd10: begin
        e = (ea == 255) || (eb == 255);
        if (ea >= eb) begin
          es = ea; ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]} >> (ea - eb);
        end else begin
          es = eb; ma = {2'b01, b[22:0]}; mb = {2'b01, a[22:0]} >> (eb - ea);
        end
        s = ma + mb;
        if (s[24]) begin s = s >> 1; es = es + 1; end
        o = (es > 254);
        r = {1'b0, 8'(es), s[22:0]};
      end
      4'd11: r = ~a;
      4'd12: r = a ^ 32'h4B00_0000;
      default: begin r = 32'hDEAD_BEEF; e = 1'b1; o = 1'b1; u = 1'b1; end
    endcase
    return {r, e, o, u};
  endfunction

  always_comb {alu_result, alu_exc, alu_ovf, alu_unf} = alu_model(alu_a, alu_b, alu_op);

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'd1) return MUL_LAT;
    if (op == 4'd2) return DIV_LAT;
    if (op == 4'd3 || op == 4'd10) return ADD_LAT;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Arbitration model and operand-hold checks; also creates scoreboard entries on grants.
  task automatic check_arb();
    int w;
    logic [NREQ-1:0] exp_rdy;
    logic [34:0] res;
    exp_t e;
    w = -1;
    exp_rdy = '0;
    if (!rst && !in_flight) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (!rst) chk("busy", 32'(busy), 32'(in_flight));
    if (!rst && in_flight) begin
      chk("alu_a_hold", alu_a, h_a);
      chk("alu_b_hold", alu_b, h_b);
      chk("alu_op_hold", 32'(alu_op), 32'(h_op));
    end
    if (rst) begin
      in_flight = 0;
      m_ptr = 0;
    end else if (w >= 0) begin
      h_a  = req_a[w*32 +: 32];
      h_b  = req_b[w*32 +: 32];
      h_op = req_op[w*4 +: 4];
      res  = alu_model(h_a, h_b, h_op);
      e.tag = w; e.lat = lat_of(h_op); e.gcyc = cyc;
      if (h_op >= 4'd1 && h_op <= 4'd12) begin
        e.data = res[34:3]; e.exc = res[2]; e.ovf = res[1]; e.unf = res[0];
      end else begin
        e.data = 32'd0; e.exc = 1'b1; e.ovf = 1'b0; e.unf = 1'b0;
      end
      sbq.push_back(e);
      grant_log.push_back(w);
      granted_mask[w] = 1'b1;
      in_flight = 1;
      m_ptr = (w + 1) % NREQ;
    end else if (in_flight && resp_valid && resp_ready) begin
      in_flight = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_arb();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*4 +: 4]  = op;
    req_valid[i]      = 1'b1;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    set_req(i, a, b, op);
    granted_mask = '0;
    for (int t = 0; t < 50 && !granted_mask[i]; t++) tick();
    chk("grant_seen", 32'(granted_mask[i]), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (in_flight || sbq.size() != 0); t++) tick();
    chk("drain_done", 32'(in_flight || sbq.size() != 0), 32'd0);
  endtask

  task automatic wait_resp_valid();
    for (int t = 0; t < 20 && !resp_valid; t++) tick();
    chk("resp_valid_seen", 32'(resp_valid), 32'd1);
  endtask

  task automatic check_reset();
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_resp_flags", {28'd0, resp_valid, resp_exc, resp_ovf, resp_unf}, 32'd0);
    chk("rst_sticky", {29'd0, sticky_exc, sticky_ovf, sticky_unf}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic reset_pulse();
    req_valid = '0;
    flag_clr  = 1'b0;
    rst = 1'b1;
    sbq.delete();
    tick();
    rst = 1'b0;
    check_reset();
  endtask

  // Response-side monitor: latency, payload, hold-during-stall and sticky model.
  exp_t        mon_e;
  bit          seen = 0;
  logic [31:0] snap_data;
  logic [31:0] snap_misc;
  logic [2:0]  m_sticky = '0;

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
      m_sticky = '0;
    end else begin
      chk("sticky", {29'd0, sticky_exc, sticky_ovf, sticky_unf}, {29'd0, m_sticky});
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp_valid", 32'(resp_valid), 32'd0);
        end else begin
          mon_e = sbq[0];
          if (!seen) begin
            seen = 1;
            chk("resp_latency", 32'(cyc - mon_e.gcyc), 32'(mon_e.lat + 1));
            chk("resp_tag", 32'(resp_tag), 32'(mon_e.tag));
            chk("resp_data", resp_data, mon_e.data);
            chk("resp_flags", {29'd0, resp_exc, resp_ovf, resp_unf},
                {29'd0, mon_e.exc, mon_e.ovf, mon_e.unf});
            snap_data = resp_data;
            snap_misc = {27'd0, resp_tag, resp_exc, resp_ovf, resp_unf};
          end else begin
            chk("resp_hold_data", resp_data, snap_data);
            chk("resp_hold_misc", {27'd0, resp_tag, resp_exc, resp_ovf, resp_unf}, snap_misc);
          end
          if (resp_ready) begin
            void'(sbq.pop_front());
            seen = 0;
            m_sticky = flag_clr ? 3'b000 : (m_sticky | {mon_e.exc, mon_e.ovf, mon_e.unf});
          end else if (flag_clr) begin
            m_sticky = '0;
          end
        end
      end else if (flag_clr) begin
        m_sticky = '0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int s;
    for (int t = 0; t < 3; t++) tick();
    rst = 1'b0;
    check_reset();

    issue(1, 32'h3F80_0000, 32'h4000_0000, 4'd10);
    drain();
    chk("add_data", resp_data, 32'h4040_0000);
    chk("add_tag", 32'(resp_tag), 32'd1);

    reset_pulse();
    s = grant_log.size();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 4'd4);
    for (int t = 0; t < 100 && grant_log.size() < s + 5; t++) tick();
    req_valid = '0;
    drain();
    chk("rr_count", 32'(grant_log.size() - s), 32'd5);
    if (grant_log.size() >= s + 5)
      for (int k = 0; k < 5; k++) chk("rr_order", 32'(grant_log[s+k]), 32'(k % NREQ));

    resp_ready = 1'b0;
    set_req(0, $urandom, $urandom, 4'd5);
    issue(2, 32'h4080_0000, 32'h4000_0000, 4'd2);
    req_valid[0] = 1'b1;
    wait_resp_valid();
    for (int t = 0; t < 5; t++) tick();
    resp_ready = 1'b1;
    granted_mask = '0;
    for (int t = 0; t < 20 && !granted_mask[0]; t++) tick();
    req_valid[0] = 1'b0;
    drain();

    issue(1, 32'h7F00_0000, 32'h7F00_0000, 4'd1);
    drain();
    chk("mul_resp_ovf", 32'(resp_ovf), 32'd1);
    chk("mul_sticky_ovf", 32'(sticky_ovf), 32'd1);
    resp_ready = 1'b0;
    issue(1, 32'h7F00_0000, 32'h7F00_0000, 4'd1);
    wait_resp_valid();
    resp_ready = 1'b1;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    tick();
    chk("clr_sticky_ovf", 32'(sticky_ovf), 32'd0);

    issue(3, $urandom, $urandom, 4'd14);
    drain();
    chk("illegal_data", resp_data, 32'd0);
    chk("illegal_exc", 32'(resp_exc), 32'd1);
    chk("illegal_sticky_exc", 32'(sticky_exc), 32'd1);

    issue(2, 32'h4100_0000, 32'h4000_0000, 4'd2);
    tick();
    tick();
    chk("div_busy", 32'(busy), 32'd1);
    reset_pulse();
    for (int t = 0; t < 8; t++) tick();
    chk("no_resp_after_rst", 32'(resp_valid), 32'd0);

    granted_mask = '0;
    for (int c = 0; c < 600; c++) begin
      tick();
      resp_ready = ($urandom_range(0, 9) < 7);
      flag_clr   = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (granted_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 9) < 4)
          set_req(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      granted_mask = '0;
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    flag_clr   = 1'b0;
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
